// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the data-memory access unit.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;   // 2'd3 also decodes as word

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_t;

    // Request fields that must survive past the accept cycle.
    typedef struct packed {
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] wdat;
    } req_t;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        sgn,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        if (size[1]) begin
            r = word;
        end else if (size == SZ_HALF) begin
            r = {{16{sgn & h[15]}}, h};
        end else begin
            r = {{24{sgn & b[7]}}, b};
        end
        return r;
    endfunction

    // Overlay right-aligned store data onto the addressed lane of a word.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdat,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        if (size[1]) begin
            r = wdat;
        end else if (size == SZ_HALF) begin
            if (off[1]) r[31:16] = wdat[15:0];
            else        r[15:0]  = wdat[15:0];
        end else begin
            r[{off, 3'b000} +: 8] = wdat[7:0];
        end
        return r;
    endfunction

    // Half needs even address, word needs 4-byte alignment; bytes never trap.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic r;
        if (size[1])              r = (off != 2'b00);
        else if (size == SZ_HALF) r = off[0];
        else                      r = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane alignment: extract+extend load data, merge sub-word store data into a read word.
// Latency: combinational.
// Backpressure: none (pure datapath).
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdat,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  off,
    output logic [31:0] load_dat,
    output logic [31:0] merge_dat
);

    // Both results are always computed; the FSM picks whichever its state needs.
    always_comb begin
        load_dat  = lane_extract(rd_word, size, sgn, off);
        merge_dat = lane_merge(rd_word, wdat, size, off);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator to a negedge-sampled word memory; sub-word stores via read-modify-write.
// Latency: load/word store respond 2 cycles after accept, byte/half store 3 (misaligned trap 1).
// Backpressure: ReqReady only in IDLE; Stall = ReqValid & ~ReqReady. Option macro: MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic [31:0] RespRData,
    output logic        Stall,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        MisalignErr
`endif
);

    state_t      state_q,    state_d;
    req_t        req_q,      req_d;
    logic        ready_q,    ready_d;
    logic        resp_vld_q, resp_vld_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        rd_q,       rd_d;
    logic        wr_q,       wr_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdat_q,     wdat_d;
`ifdef MISALIGN_TRAP_EN
    logic        err_q,      err_d;
`endif

    logic [31:0] load_dat;
    logic [31:0] merge_dat;

    // Address bits above the memory depth wrap; they are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ReqAddr[31:ADDR_W+2];

    mem_lane_align u_lane (
        .rd_word   (MemReadData),
        .wdat      (req_q.wdat),
        .size      (req_q.size),
        .sgn       (req_q.sgn),
        .off       (req_q.off),
        .load_dat  (load_dat),
        .merge_dat (merge_dat)
    );

    // Next-state and next-output decode; every memory strobe is a one-cycle pulse.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        resp_vld_d = 1'b0;
        rdata_d    = 32'd0;
`ifdef MISALIGN_TRAP_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ReqValid) begin
                    req_d.size = ReqSize;
                    req_d.sgn  = ReqSigned;
                    req_d.off  = ReqAddr[1:0];
                    req_d.wdat = ReqWData;
                    addr_d     = {{(32-ADDR_W){1'b0}}, ReqAddr[ADDR_W+1:2]};
`ifdef MISALIGN_TRAP_EN
                    if (is_misaligned(ReqSize, ReqAddr[1:0])) begin
                        state_d    = ST_RESP;
                        resp_vld_d = 1'b1;
                        err_d      = 1'b1;
                    end else
`endif
                    if (!ReqWrite) begin
                        state_d = ST_RD;
                        rd_d    = 1'b1;
                    end else if (ReqSize[1]) begin
                        state_d = ST_WR;
                        wr_d    = 1'b1;
                        wdat_d  = ReqWData;
                    end else begin
                        state_d = ST_RMW_RD;
                        rd_d    = 1'b1;
                    end
                end
            end
            ST_RD: begin
                state_d    = ST_RESP;
                resp_vld_d = 1'b1;
                rdata_d    = load_dat;
            end
            ST_WR: begin
                state_d    = ST_RESP;
                resp_vld_d = 1'b1;
            end
            ST_RMW_RD: begin
                state_d = ST_RMW_WR;
                wr_d    = 1'b1;
                wdat_d  = merge_dat;
            end
            ST_RMW_WR: begin
                state_d    = ST_RESP;
                resp_vld_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; synchronous reset abandons any access in flight.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            ready_q    <= 1'b1;
            resp_vld_q <= 1'b0;
            rdata_q    <= 32'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdat_q     <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            ready_q    <= ready_d;
            resp_vld_q <= resp_vld_d;
            rdata_q    <= rdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
`ifdef MISALIGN_TRAP_EN
            err_q      <= err_d;
`endif
        end
    end

    assign ReqReady     = ready_q;
    assign Stall        = ReqValid & ~ready_q;
    assign RespValid    = resp_vld_q;
    assign RespRData    = rdata_q;
    assign MemRead      = rd_q;
    assign MemWrite     = wr_q;
    assign MemAddress   = addr_q;
    assign MemWriteData = wdat_q;
`ifdef MISALIGN_TRAP_EN
    assign MisalignErr  = err_q;
`endif

endmodule
